// File: rtl/pattern_align_pkg.sv
// Shared types and helpers for the pattern_align frame aligner.
package pattern_align_pkg;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    // Widest word the masked compare helper accepts.
    localparam int unsigned MAXW = 64;

    function automatic int off_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic hit_vec(input logic [MAXW-1:0] cand,
                                     input logic [MAXW-1:0] pat,
                                     input logic [MAXW-1:0] mask);
        return ((cand ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/pattern_align_if.sv
// Raw capture input and aligned frame output of pattern_align.
interface pattern_align_if import pattern_align_pkg::*; #(
    parameter int WIDTH = 16
) ();
    localparam int OW = off_w(WIDTH);

    logic             ena;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_sof;
    logic             locked;
    logic [OW-1:0]    offset;
    logic             lock_lost;

    modport master (
        output ena, data,
        input  out_data, out_valid, out_sof, locked, offset, lock_lost
    );

    modport slave (
        input  ena, data,
        output out_data, out_valid, out_sof, locked, offset, lock_lost
    );
endinterface

// File: rtl/pattern_window_match.sv
// Two-word sliding window with per-offset masked sync compare and aligned-word mux.
module pattern_window_match import pattern_align_pkg::*; #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PAT      = 16'hA5C3,
    parameter logic [WIDTH-1:0] PAT_MASK = '1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      ena_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic [off_w(WIDTH)-1:0]   off_i,
    output logic [WIDTH-1:0]          hit_o,
    output logic [off_w(WIDTH)-1:0]   low_idx_o,
    output logic                      any_hit_o,
    output logic                      win_valid_o,
    output logic [WIDTH-1:0]          word_o
);
    localparam int OW = off_w(WIDTH);

    logic [WIDTH-1:0]   prev_q, cur_q;
    logic [1:0]         wcnt_q;
    logic [2*WIDTH-1:0] win;
    logic               found;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_q <= '0;
            cur_q  <= '0;
            wcnt_q <= '0;
        end else if (ena_i) begin
            prev_q <= cur_q;
            cur_q  <= data_i;
            if (!wcnt_q[1]) wcnt_q <= wcnt_q + 2'd1;
        end
    end

    assign win         = {prev_q, cur_q};
    assign win_valid_o = wcnt_q[1];
    assign word_o      = win[off_i +: WIDTH];

    always_comb begin
        hit_o     = '0;
        low_idx_o = '0;
        found     = 1'b0;
        for (int unsigned o = 0; o < WIDTH; o++) begin
            hit_o[o] = hit_vec(MAXW'(win[o +: WIDTH]), MAXW'(PAT), MAXW'(PAT_MASK));
            if (hit_o[o] && !found) begin
                low_idx_o = OW'(o);
                found     = 1'b1;
            end
        end
        any_hit_o = found;
    end

endmodule

// File: rtl/pattern_align.sv
// Frame aligner: bit-offset sync search, lock confirmation at frame period,
// aligned output with start-of-frame marking and miss-hysteresis lock loss.
module pattern_align import pattern_align_pkg::*; #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] PAT       = 16'hA5C3,
    parameter logic [WIDTH-1:0] PAT_MASK  = '1,
    parameter int               FRAME_LEN = 8,
    parameter int               LOCK_CNT  = 3,
    parameter int               LOSS_CNT  = 2
) (
    input  logic          clk,
    input  logic          nrst,
    pattern_align_if.slave bus
);
    localparam int OW  = off_w(WIDTH);
    localparam int FCW = off_w(FRAME_LEN);
    localparam int HCW = off_w(LOCK_CNT + 1);
    localparam int MCW = off_w(LOSS_CNT + 1);

    state_t           state_q, state_d;
    logic             eval_q;
    logic [OW-1:0]    offset_q, offset_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d, fcnt_nxt;
    logic [HCW-1:0]   hits_q, hits_d;
    logic [MCW-1:0]   misses_q, misses_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    logic             lock_lost_q, lock_lost_d;

    logic [WIDTH-1:0] hit;
    logic [OW-1:0]    low_idx;
    logic             any_hit, win_valid;
    logic [WIDTH-1:0] aligned;
    logic             eval, sync_slot, sync_hit;

    pattern_window_match #(
        .WIDTH    (WIDTH),
        .PAT      (PAT),
        .PAT_MASK (PAT_MASK)
    ) u_win (
        .clk         (clk),
        .nrst        (nrst),
        .ena_i       (bus.ena),
        .data_i      (bus.data),
        .off_i       (offset_q),
        .hit_o       (hit),
        .low_idx_o   (low_idx),
        .any_hit_o   (any_hit),
        .win_valid_o (win_valid),
        .word_o      (aligned)
    );

    // A word accepted in one cycle is judged in the next, once the window holds two words.
    assign eval      = eval_q & win_valid;
    assign fcnt_nxt  = (fcnt_q == FCW'(FRAME_LEN - 1)) ? '0 : fcnt_q + FCW'(1);
    assign sync_slot = (fcnt_nxt == '0);
    assign sync_hit  = hit[offset_q];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= SEARCH;
            eval_q      <= 1'b0;
            offset_q    <= '0;
            fcnt_q      <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            eval_q      <= bus.ena;
            offset_q    <= offset_d;
            fcnt_q      <= fcnt_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        fcnt_d   = fcnt_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        if (eval) begin
            case (state_q)
                SEARCH: begin
                    if (any_hit) begin
                        offset_d = low_idx;
                        fcnt_d   = '0;
                        hits_d   = HCW'(1);
                        misses_d = '0;
                        state_d  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    fcnt_d = fcnt_nxt;
                    if (sync_slot) begin
                        if (sync_hit) begin
                            hits_d = hits_q + HCW'(1);
                            if (hits_d == HCW'(LOCK_CNT)) begin
                                misses_d = '0;
                                state_d  = LOCKED;
                            end
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    fcnt_d = fcnt_nxt;
                    if (sync_slot) begin
                        if (sync_hit) begin
                            misses_d = '0;
                        end else begin
                            misses_d = misses_q + MCW'(1);
                            if (misses_d == MCW'(LOSS_CNT)) state_d = SEARCH;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // The losing sync slot is still emitted; only lock_lost flags it.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        lock_lost_d = 1'b0;
        if (eval && state_q == LOCKED) begin
            out_data_d  = aligned;
            out_valid_d = 1'b1;
            out_sof_d   = sync_slot;
            lock_lost_d = (state_d == SEARCH);
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.offset    = offset_q;
    assign bus.lock_lost = lock_lost_q;

endmodule
